ifetch_unit: RTL and testbench

Instruction fetch unit between the PC generator and instruction memory. It accepts fetch addresses (`next_pc` / `next_pc_valide` from the PC generator) and issues single-word reads on a req/gnt/rvalid memory port. It returns `{instruction, pc}` pairs in program order through a small output buffer to the PC generator's `instruction`/`ok` input. Flush discards every fetch not yet delivered, including reads already granted by memory.

---
 rtl/ifetch_unit.sv | 135 +++++++++++++
 tb/tb_ifetch_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: takes fetch addresses from the PC generator, issues
// single-word reads on a req/gnt/rvalid port, and returns {instruction, pc}
// pairs in program order through a small output FIFO. A flush discards every
// undelivered fetch, including reads that memory has already granted.
module ifetch_unit #(
  parameter int xlen  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [xlen-1:0] pc_i,
  input  logic            pc_valid_i,
  output logic            pc_ready_o,
  input  logic            flush_i,
  output logic            mem_req_o,
  output logic [xlen-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [31:0]     mem_rdata_i,
  output logic [31:0]     instr_o,
  output logic [xlen-1:0] instr_pc_o,
  output logic            instr_valid_o,
  input  logic            instr_ready_i
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;

  // Occupancy counters
  cnt_t pend;     // registered request not yet granted (0/1)
  cnt_t infl;     // granted, response outstanding, still wanted
  cnt_t buf_cnt;  // entries waiting in the output FIFO
  cnt_t drop;     // granted responses that must be discarded

  // In-flight PC queue: one entry per accepted fetch until its data returns
  logic [xlen-1:0] pc_q [DEPTH];
  ptr_t            pcq_wr, pcq_rd;

  // Output FIFO
  logic [31:0]     ob_instr [DEPTH];
  logic [xlen-1:0] ob_pc    [DEPTH];
  ptr_t            ob_wr, ob_rd;

  logic [xlen-1:0] addr_q;

  logic        accept, gnt_fire, rv_drop, rv_take, out_pop;
  logic [CW:0] occupancy;

  // Dropped responses are not counted here: they belong to a discarded fetch.
  assign occupancy  = {1'b0, infl} + {1'b0, buf_cnt};
  assign pc_ready_o = !rst && !flush_i && (pend == '0) && (occupancy < DEPTH_C);
  assign accept     = pc_valid_i && pc_ready_o;

  assign mem_req_o  = (pend != '0);
  assign mem_addr_o = addr_q;
  assign gnt_fire   = mem_req_o && mem_gnt_i;

  // A response first pays off any pending drops; only then does it carry data.
  assign rv_drop = mem_rvalid_i && (drop != '0);
  assign rv_take = mem_rvalid_i && (drop == '0) && (infl != '0);

  assign instr_valid_o = (buf_cnt != '0) && !flush_i;
  assign out_pop       = instr_valid_o && instr_ready_i;

  // NOTE: FIFO storage is not reset, so the outputs are masked to zero while
  // the buffer is empty instead of exposing stale or unknown slots.
  assign instr_o    = (buf_cnt != '0) ? ob_instr[ob_rd] : '0;
  assign instr_pc_o = (buf_cnt != '0) ? ob_pc[ob_rd]    : '0;

  // Counter, request-port and pointer updates; flush overrides normal traffic.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every update in
    // this block sees the pre-edge values of the other counters.
    if (rst) begin
      pend    <= '0;
      infl    <= '0;
      buf_cnt <= '0;
      drop    <= '0;
      addr_q  <= '0;
      pcq_wr  <= '0;
      pcq_rd  <= '0;
      ob_wr   <= '0;
      ob_rd   <= '0;
    end else if (flush_i) begin
      pend    <= '0;
      infl    <= '0;
      buf_cnt <= '0;
      // Everything granted and still owed becomes a drop; a response arriving
      // now is settled against the pre-flush counts.
      drop    <= drop + infl + cnt_t'(gnt_fire) - cnt_t'(rv_drop) - cnt_t'(rv_take);
      pcq_wr  <= '0;
      pcq_rd  <= '0;
      ob_wr   <= '0;
      ob_rd   <= '0;
    end else begin
      if (accept) begin
        addr_q <= {pc_i[xlen-1:2], 2'b00};
        pend   <= cnt_t'(1);
        pcq_wr <= pcq_wr + 1'b1;
      end else if (gnt_fire) begin
        pend <= '0;
      end
      infl    <= infl + cnt_t'(gnt_fire) - cnt_t'(rv_take);
      drop    <= drop - cnt_t'(rv_drop);
      buf_cnt <= buf_cnt + cnt_t'(rv_take) - cnt_t'(out_pop);
      if (rv_take) begin
        pcq_rd <= pcq_rd + 1'b1;
        ob_wr  <= ob_wr + 1'b1;
      end
      if (out_pop) begin
        ob_rd <= ob_rd + 1'b1;
      end
    end
  end

  // Queue storage writes: PC on accept, {data, pc} when a wanted response lands.
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_q[pcq_wr] <= pc_i;
    end
    if (rv_take && !flush_i && !rst) begin
      ob_instr[ob_wr] <= mem_rdata_i;
      ob_pc[ob_wr]    <= pc_q[pcq_rd];
    end
  end

  // A response with nothing outstanding is a memory-side protocol error.
  a_no_spurious_rvalid: assert property (@(posedge clk) disable iff (rst)
    !(mem_rvalid_i && (infl == '0) && (drop == '0)));

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit. Stimulus pushes expected {instr, pc} pairs
// into a scoreboard; a monitor pops and compares on every output handshake.
module tb_ifetch_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] pc_i;
  logic            pc_valid_i;
  logic            pc_ready_o;
  logic            flush_i;
  logic            mem_req_o;
  logic [XLEN-1:0] mem_addr_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [31:0]     mem_rdata_i;
  logic [31:0]     instr_o;
  logic [XLEN-1:0] instr_pc_o;
  logic            instr_valid_o;
  logic            instr_ready_i;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t sb_q[$];
  entry_t mon_e;
  int     checks = 0;
  int     errors = 0;

  ifetch_unit #(.xlen(XLEN), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .pc_valid_i   (pc_valid_i),
    .pc_ready_o   (pc_ready_o),
    .flush_i      (flush_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every delivered entry must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && instr_valid_o && instr_ready_i) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got instr 0x%0h pc 0x%0h, expected nothing", instr_o, instr_pc_o);
      end else begin
        mon_e = sb_q.pop_front();
        check("out_instr", 64'(instr_o), 64'(mon_e.instr));
        check("out_pc", 64'(instr_pc_o), 64'(mon_e.pc));
      end
    end
  end

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a);
    pc_i       = a;
    pc_valid_i = 1'b1;
    @(negedge clk);
    check("pc_ready_on_issue", 64'(pc_ready_o), 64'(1));
    cyc();
    pc_valid_i = 1'b0;
  endtask

  task automatic grant(input logic [31:0] exp_addr);
    mem_gnt_i = 1'b1;
    @(negedge clk);
    check("req_at_gnt", 64'(mem_req_o), 64'(1));
    check("addr_at_gnt", 64'(mem_addr_o), 64'(exp_addr));
    cyc();
    mem_gnt_i = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data, input logic [31:0] pc, input bit keep);
    if (keep) sb_q.push_back('{instr: data, pc: pc});
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = data;
    cyc();
    mem_rvalid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    pc_i          = '0;
    pc_valid_i    = 1'b0;
    flush_i       = 1'b0;
    mem_gnt_i     = 1'b0;
    mem_rvalid_i  = 1'b0;
    mem_rdata_i   = '0;
    instr_ready_i = 1'b1;

    // Reset state
    cyc();
    cyc();
    @(negedge clk);
    check("rst_pc_ready", 64'(pc_ready_o), 64'(0));
    check("rst_mem_req", 64'(mem_req_o), 64'(0));
    check("rst_mem_addr", 64'(mem_addr_o), 64'(0));
    check("rst_valid", 64'(instr_valid_o), 64'(0));
    check("rst_instr", 64'(instr_o), 64'(0));
    check("rst_instr_pc", 64'(instr_pc_o), 64'(0));
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(pc_ready_o), 64'(1));
    cyc();

    // Single fetch, minimum latency
    issue(32'h100);
    check("req_after_accept", 64'(mem_req_o), 64'(1));
    grant(32'h100);
    check("req_low_after_gnt", 64'(mem_req_o), 64'(0));
    respond(32'h0000_0013, 32'h100, 1'b1);
    check("lat3_valid", 64'(instr_valid_o), 64'(1));
    cyc();

    // Back-pressure: buffer fills, pc_ready drops, order preserved on release
    instr_ready_i = 1'b0;
    issue(32'h0);
    grant(32'h0);
    respond(32'h1111_1111, 32'h0, 1'b1);
    issue(32'h4);
    grant(32'h4);
    respond(32'h2222_2222, 32'h4, 1'b1);
    check("full_ready_low", 64'(pc_ready_o), 64'(0));
    check("full_valid", 64'(instr_valid_o), 64'(1));
    cyc();
    check("full_ready_hold", 64'(pc_ready_o), 64'(0));
    check("full_head_instr", 64'(instr_o), 64'(32'h1111_1111));
    instr_ready_i = 1'b1;
    cyc();
    check("ready_after_pop", 64'(pc_ready_o), 64'(1));
    cyc();
    check("drained_valid", 64'(instr_valid_o), 64'(0));

    // Flush with two granted, unreturned reads
    issue(32'h10);
    grant(32'h10);
    issue(32'h14);
    grant(32'h14);
    check("infl_full_ready", 64'(pc_ready_o), 64'(0));
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    respond(32'h0000_AAAA, 32'h10, 1'b0);
    check("drop1_no_valid", 64'(instr_valid_o), 64'(0));
    respond(32'h0000_BBBB, 32'h14, 1'b0);
    check("drop2_no_valid", 64'(instr_valid_o), 64'(0));
    issue(32'h200);
    grant(32'h200);
    respond(32'hC0DE_0200, 32'h200, 1'b1);
    cyc();

    // Flush of an ungranted request
    issue(32'h300);
    check("req_pending", 64'(mem_req_o), 64'(1));
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    check("req_withdrawn", 64'(mem_req_o), 64'(0));
    issue(32'h304);
    grant(32'h304);
    respond(32'h3043_0430, 32'h304, 1'b1);
    cyc();

    // Flush together with rvalid and an output pop
    instr_ready_i = 1'b0;
    issue(32'h400);
    grant(32'h400);
    respond(32'h4040_4040, 32'h400, 1'b0);
    issue(32'h404);
    grant(32'h404);
    instr_ready_i = 1'b1;
    flush_i       = 1'b1;
    mem_rvalid_i  = 1'b1;
    mem_rdata_i   = 32'hDEAD_BEEF;
    @(negedge clk);
    check("flush_valid_low", 64'(instr_valid_o), 64'(0));
    cyc();
    flush_i      = 1'b0;
    mem_rvalid_i = 1'b0;
    check("flush_buf_empty", 64'(instr_valid_o), 64'(0));
    issue(32'h500);
    grant(32'h500);
    respond(32'h5050_5050, 32'h500, 1'b1);
    cyc();

    // Misaligned PC, then grant and rvalid in the same cycle
    issue(32'h103);
    grant(32'h100);
    issue(32'h108);
    sb_q.push_back('{instr: 32'h0303_0303, pc: 32'h103});
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h0303_0303;
    @(negedge clk);
    check("addr_aligned_108", 64'(mem_addr_o), 64'(32'h108));
    cyc();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    check("req_low_gnt_rv", 64'(mem_req_o), 64'(0));
    check("valid_after_gnt_rv", 64'(instr_valid_o), 64'(1));
    respond(32'h0808_0808, 32'h108, 1'b1);

    repeat (4) cyc();
    check("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
